mp64_trng_arb: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one `mp64_trng` MMIO port among `N_PORTS` requesters (cores, DMA, boot ROM). It serialises requests, drives the TRNG's req/addr/wdata/wen handshake, captures rdata on ack, and returns it to the granted requester. A downstream timeout prevents a stalled TRNG from hanging a core.

---
 rtl/mp64_trng_arb_pkg.sv | 17 +
 rtl/mp64_rr_pick.sv | 36 +++
 rtl/mp64_trng_arb.sv | 174 +++++++++++++++++
 tb/tb_mp64_trng_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp64_trng_arb_pkg.sv
// Shared definitions for the mp64 TRNG arbiter: TRNG register offsets and
// the SEED-lock decode used when MP64_TRNG_SEED_LOCK_EN is defined.
package mp64_trng_arb_pkg;

    localparam logic [4:0] TRNG_RAND8  = 5'h00;
    localparam logic [4:0] TRNG_RAND64 = 5'h08;
    localparam logic [4:0] TRNG_STATUS = 5'h10;
    localparam logic [4:0] TRNG_SEED   = 5'h18;

    // Only port 0 (boot/secure master) may reseed once the lock is built in.
    function automatic logic is_locked_seed_write(input logic [4:0] addr,
                                                  input logic       wen,
                                                  input logic       from_port0);
        return wen && (addr == TRNG_SEED) && !from_port0;
    endfunction

endpackage

// File: rtl/mp64_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping modulo N. Produces a one-hot grant, its index and a valid flag.
module mp64_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx,
    output logic            valid
);

    always_comb begin
        int unsigned j;
        logic [IdxW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        j       = 0;
        idx     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = int'(last) + k;
            if (j >= N) begin
                j = j - N;
            end
            idx = IdxW'(j);
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mp64_trng_arb.sv
// Round-robin sequencer sharing one mp64_trng MMIO port among N_PORTS masters,
// with downstream timeout. Define MP64_TRNG_SEED_LOCK_EN to block non-port-0 SEED writes.
module mp64_trng_arb
    import mp64_trng_arb_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PORTS-1:0]    p_req,
    input  logic [N_PORTS*5-1:0]  p_addr,
    input  logic [N_PORTS*64-1:0] p_wdata,
    input  logic [N_PORTS-1:0]    p_wen,
    output logic [63:0]           p_rdata,
    output logic [N_PORTS-1:0]    p_ack,
    output logic                  p_err,
    output logic                  t_req,
    output logic [4:0]            t_addr,
    output logic [63:0]           t_wdata,
    output logic                  t_wen,
    input  logic [63:0]           t_rdata,
    input  logic                  t_ack
);

    localparam int unsigned IdxW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          TimeoutEn = (TIMEOUT != 0);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [4:0]      addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            wen_q, wen_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [N_PORTS-1:0] pick_gnt;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_valid;
    logic [4:0]         sel_addr;
    logic [63:0]        sel_wdata;
    logic               sel_wen;

    mp64_rr_pick #(
        .N(N_PORTS)
    ) u_pick (
        .req    (p_req),
        .last   (last_q),
        .gnt    (pick_gnt),
        .gnt_idx(pick_idx),
        .valid  (pick_valid)
    );

    // AND-OR select of the winning port's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wen   = 1'b0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (pick_gnt[i]) begin
                sel_addr  = sel_addr | p_addr[5*i +: 5];
                sel_wdata = sel_wdata | p_wdata[64*i +: 64];
                sel_wen   = sel_wen | p_wen[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= IdxW'(N_PORTS - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wen_d   = sel_wen;
                    cnt_d   = '0;
`ifdef MP64_TRNG_SEED_LOCK_EN
                    if (is_locked_seed_write(sel_addr, sel_wen, pick_idx == '0)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
`else
                    state_d = StIssue;
`endif
                end
            end
            StIssue: begin
                if (t_ack) begin
                    rdata_d = t_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A late ack in the timeout cycle still delivers real data.
                if (t_ack) begin
                    rdata_d = t_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                last_d  = gnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are register copies or state decodes; rst gating keeps the reset cycle quiet.
    always_comb begin
        t_req   = (state_q == StIssue) && !rst;
        t_addr  = addr_q;
        t_wdata = wdata_q;
        t_wen   = wen_q;
        p_rdata = rdata_q;
        p_err   = (state_q == StResp) && err_q;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            p_ack[i] = (state_q == StResp) && !rst && (gnt_q == IdxW'(i));
        end
    end

endmodule

// File: tb/tb_mp64_trng_arb.sv
// Self-checking bench for mp64_trng_arb: directed scenarios plus randomized
// transactions checked against a round-robin/latency reference model.
module tb_mp64_trng_arb;
    import mp64_trng_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    p_req;
    logic [N*5-1:0]  p_addr;
    logic [N*64-1:0] p_wdata;
    logic [N-1:0]    p_wen;
    logic [63:0]     p_rdata;
    logic [N-1:0]    p_ack;
    logic            p_err;
    logic            t_req;
    logic [4:0]      t_addr;
    logic [63:0]     t_wdata;
    logic            t_wen;
    logic [63:0]     t_rdata;
    logic            t_ack;

    mp64_trng_arb #(
        .N_PORTS(N),
        .TIMEOUT(TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .p_req  (p_req),
        .p_addr (p_addr),
        .p_wdata(p_wdata),
        .p_wen  (p_wen),
        .p_rdata(p_rdata),
        .p_ack  (p_ack),
        .p_err  (p_err),
        .t_req  (t_req),
        .t_addr (t_addr),
        .t_wdata(t_wdata),
        .t_wen  (t_wen),
        .t_rdata(t_rdata),
        .t_ack  (t_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: who was served last, and per-port request contents.
    int          last_m = N - 1;
    logic [4:0]  a_m [N];
    logic [63:0] w_m [N];
    logic        wn_m[N];

    // TRNG model: ack ack_delay cycles after t_req (-1 = never).
    int          ack_delay = -1;
    logic [63:0] ack_data  = '0;

    initial begin
        bit pend;
        int k;
        pend    = 1'b0;
        k       = 0;
        t_ack   = 1'b0;
        t_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            t_ack = 1'b0;
            if (t_req) begin
                pend = 1'b1;
                k    = 0;
            end
            if (pend && k == ack_delay) begin
                t_ack   = 1'b1;
                t_rdata = ack_data;
                pend    = 1'b0;
            end
            k++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr(input int last, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic rand_ports();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(2))
                0:       a_m[i] = TRNG_RAND8;
                1:       a_m[i] = TRNG_RAND64;
                default: a_m[i] = TRNG_STATUS;
            endcase
            w_m[i]  = {$urandom, $urandom};
            wn_m[i] = 1'($urandom_range(1));
        end
    endtask

    task automatic drive_ports();
        for (int i = 0; i < N; i++) begin
            p_addr[5*i +: 5]   = a_m[i];
            p_wdata[64*i +: 64] = w_m[i];
            p_wen[i]           = wn_m[i];
        end
    endtask

    // Called in an IDLE cycle; ends in the following IDLE cycle with p_req low.
    task automatic do_txn(input logic [N-1:0] reqv, input int delay,
                          input logic [63:0] data, input bit drop);
        int e;
        int cyc;
        int exp_cyc;
        ack_delay = delay;
        ack_data  = data;
        e         = rr(last_m, reqv);
        p_req     = reqv;
        tick();
        chk("t_req_issue", 64'(t_req), 64'(1));
        chk("t_addr", 64'(t_addr), 64'(a_m[e]));
        chk("t_wdata", t_wdata, w_m[e]);
        chk("t_wen", 64'(t_wen), 64'(wn_m[e]));
        if (drop) p_req = '0;
        cyc = 1;
        while (p_ack == '0 && cyc < TO + 10) begin
            tick();
            cyc++;
            if (p_ack == '0) chk("t_req_quiet", 64'(t_req), 64'(0));
        end
        exp_cyc = (delay < 0) ? TO + 2 : delay + 2;
        chk("ack_cycle", 64'(cyc), 64'(exp_cyc));
        chk("p_ack", 64'(p_ack), 64'(1) << e);
        chk("p_rdata", p_rdata, (delay < 0) ? '1 : data);
        chk("p_err", 64'(p_err), 64'(delay < 0));
        p_req = '0;
        tick();
        chk("p_ack_idle", 64'(p_ack), 64'(0));
        last_m = e;
    endtask

    initial begin
        int exp_p;
        int cyc;
        int n;
        rst     = 1'b1;
        p_req   = '0;
        p_addr  = '0;
        p_wdata = '0;
        p_wen   = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_t_req", 64'(t_req), 64'(0));
        chk("rst_t_addr", 64'(t_addr), 64'(0));
        chk("rst_t_wdata", t_wdata, 64'(0));
        chk("rst_t_wen", 64'(t_wen), 64'(0));
        chk("rst_p_ack", 64'(p_ack), 64'(0));
        chk("rst_p_err", 64'(p_err), 64'(0));
        chk("rst_p_rdata", p_rdata, 64'(0));

        // Fairness: all four hold requests for RAND64, acks land 3 cycles apart.
        for (int i = 0; i < N; i++) begin
            a_m[i]  = TRNG_RAND64;
            w_m[i]  = '0;
            wn_m[i] = 1'b0;
        end
        drive_ports();
        ack_delay = 0;
        ack_data  = 64'hC0FF_EE00_1234_5678;
        p_req     = '1;
        cyc       = 0;
        exp_p     = last_m;
        for (n = 0; n < 5; n++) begin
            exp_p = (exp_p + 1) % N;
            tick();
            cyc++;
            while (p_ack == '0 && cyc < 40) begin
                tick();
                cyc++;
            end
            chk("fair_cycle", 64'(cyc), 64'(2 + 3 * n));
            chk("fair_p_ack", 64'(p_ack), 64'(1) << exp_p);
            chk("fair_rdata", p_rdata, ack_data);
        end
        p_req = '0;
        tick();
        last_m = exp_p;

        // Port 2 reads STATUS with same-cycle ack.
        rand_ports();
        a_m[2]  = TRNG_STATUS;
        wn_m[2] = 1'b0;
        drive_ports();
        do_txn(4'b0100, 0, 64'h1, 1'b0);

        // Timeout, then a normal transaction.
        rand_ports();
        drive_ports();
        do_txn(4'b1000, -1, 64'h0, 1'b0);
        rand_ports();
        drive_ports();
        do_txn(4'b0011, 3, {$urandom, $urandom}, 1'b0);

        // Ack arrives in the timeout cycle itself.
        rand_ports();
        drive_ports();
        do_txn(4'b0001, TO, 64'h5A, 1'b0);

        // Port 1 SEED write.
        rand_ports();
        a_m[1]  = TRNG_SEED;
        wn_m[1] = 1'b1;
        w_m[1]  = 64'h1234_5678_90AB_CDEF;
        drive_ports();
`ifdef MP64_TRNG_SEED_LOCK_EN
        p_req = 4'b0010;
        tick();
        chk("seed_t_req", 64'(t_req), 64'(0));
        chk("seed_p_ack", 64'(p_ack), 64'(2));
        chk("seed_p_err", 64'(p_err), 64'(1));
        chk("seed_p_rdata", p_rdata, 64'(0));
        p_req = '0;
        tick();
        last_m = 1;
`else
        do_txn(4'b0010, 0, 64'h0, 1'b0);
`endif
        // Port 0 SEED write is always forwarded.
        rand_ports();
        a_m[0]  = TRNG_SEED;
        wn_m[0] = 1'b1;
        drive_ports();
        do_txn(4'b0001, 1, {$urandom, $urandom}, 1'b0);

        // Reset while waiting on a silent TRNG.
        rand_ports();
        drive_ports();
        ack_delay = -1;
        p_req     = 4'b0100;
        tick();
        tick();
        tick();
        rst   = 1'b1;
        p_req = '0;
        #1;
        chk("rstw_t_req", 64'(t_req), 64'(0));
        chk("rstw_p_ack", 64'(p_ack), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("rstw_idle_t_req", 64'(t_req), 64'(0));
        chk("rstw_idle_p_ack", 64'(p_ack), 64'(0));
        last_m = N - 1;
        do_txn(4'b1111, 2, {$urandom, $urandom}, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] rq;
            int           d;
            rq = N'($urandom_range(15, 1));
            d  = (t % 20 == 7) ? -1 : int'($urandom_range(6));
            rand_ports();
            drive_ports();
            do_txn(rq, d, {$urandom, $urandom}, 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
